keep_cnt_conv: RTL and testbench
================================

Name: keep_cnt_conv

Overview:
- Registered, bidirectional converter between AXI-Stream byte-enable masks (tkeep) and byte counts, for the 10G Ethernet datapath.
- The keep-to-count channel sizes a beat, for example to accumulate frame byte counts in the checksum engine.
- The count-to-keep channel builds a low-justified byte mask from a byte offset, for example to mask bytes before the checksum start.
- The two channels are independent and fully pipelined, each with 1-cycle latency.

Parameters:
- C_KEEP_WIDTH, 8, number of byte lanes; legal range 1..16.
- C_CNT_WIDTH, 4, count width; must satisfy 2**C_CNT_WIDTH > C_KEEP_WIDTH.

Ports:
- clk  in  1  rising-edge clock for everything.
- rst  in  1  synchronous, active-high reset.
- k2c_valid  in  1  k2c_keep is valid this cycle.
- k2c_keep  in  C_KEEP_WIDTH  byte-enable mask; bit i = lane i.
- k2c_cnt_valid  out  1  k2c_cnt / k2c_noncontig are valid.
- k2c_cnt  out  C_CNT_WIDTH  number of set bits in the captured mask.
- k2c_noncontig  out  1  captured mask was not of form 2**n-1.
- c2k_valid  in  1  c2k_cnt is valid this cycle.
- c2k_cnt  in  C_CNT_WIDTH  byte count / offset.
- c2k_keep_valid  out  1  c2k_keep / c2k_ovf are valid.
- c2k_keep  out  C_KEEP_WIDTH  thermometer mask, low c2k_cnt bits set.
- c2k_ovf  out  1  captured count exceeded C_KEEP_WIDTH (mask saturated).

Behaviour:
- Reset: on a rising edge with rst=1, every output register is cleared to 0 (valids, cnt, keep, flags). rst overrides a simultaneous valid input.
- No handshake/backpressure: each channel accepts one input per cycle whenever its valid is 1.
- Keep-to-count channel:
  - The registered output valid equals k2c_valid delayed one cycle.
  - When k2c_valid=1, on the next edge:
    - k2c_cnt <= popcount(k2c_keep), range 0..C_KEEP_WIDTH, zero-extended.
    - k2c_noncontig <= 1 unless k2c_keep is 0 or has all ones contiguous from bit 0 (e.g. 0x07, 0xFF). All-zero mask gives cnt 0, noncontig 0.
  - When k2c_valid=0: k2c_cnt_valid <= 0; k2c_cnt and k2c_noncontig hold their previous values.
  - Holes are counted, not rejected: 0x05 gives cnt 2 with noncontig 1.
- Count-to-keep channel:
  - The registered output valid equals c2k_valid delayed one cycle.
  - When c2k_valid=1, on the next edge:
    - If c2k_cnt <= C_KEEP_WIDTH: bit i of c2k_keep <= (i < c2k_cnt), and c2k_ovf <= 0.
    - Otherwise: c2k_keep <= all ones, and c2k_ovf <= 1.
  - When c2k_valid=0: c2k_keep_valid <= 0; data and flag hold.
- Back-to-back inputs produce back-to-back outputs with no bubbles.
- The two channels may be active in the same cycle with no interaction.
- Round trip: for any c in 0..C_KEEP_WIDTH, keep_to_cnt(cnt_to_keep(c)) = c with noncontig 0.
- Reset asserted mid-stream drops in-flight results. The first output after reset deassertion corresponds to the first valid input sampled with rst=0.
- Purely combinational conversion logic between input and output registers; no other state.

Test Plan:
- Reset: hold rst=1 with both valids=1 and k2c_keep=0xFF for 3 cycles -> all outputs 0. Release -> outputs follow inputs 1 cycle later.
- Keep-to-count sweep, W=8: apply 0x00, 0x01, 0x03, 0x0F, 0x7F, 0xFF on consecutive cycles -> cnt 0, 1, 2, 4, 7, 8, noncontig 0, valid high 6 consecutive cycles.
- Non-contiguous: k2c_keep=0x05 -> cnt 2, noncontig 1. k2c_keep=0x80 -> cnt 1, noncontig 1. k2c_keep=0xFE -> cnt 7, noncontig 1.
- Count-to-keep sweep: c2k_cnt 0..8 -> keep 0x00, 0x01, 0x03, 0x07, 0x0F, 0x1F, 0x3F, 0x7F, 0xFF, ovf 0. c2k_cnt 9 and 15 -> keep 0xFF, ovf 1.
- Gaps and hold: valid pattern 1,0,1 with k2c_keep 0x0F, then 0x03 -> output valid 1,0,1. k2c_cnt shows 4, holds 4 during the gap, then shows 2.
- Concurrent and round trip: feed c2k_cnt=c and k2c_keep=cnt_to_keep(c) every cycle for c=0..8 -> k2c_cnt=c and c2k_keep matches, no cross-channel effect.

Source files
------------

// File: rtl/keep_cnt_conv_if.sv
// keep_cnt_conv_if: keep-to-count and count-to-keep channel bundle for keep_cnt_conv.
// Rev 1.0
`default_nettype none

interface keep_cnt_conv_if #(
  parameter int C_KEEP_WIDTH = 8,
  parameter int C_CNT_WIDTH  = 4
) ();
  logic                    k2c_valid;
  logic [C_KEEP_WIDTH-1:0] k2c_keep;
  logic                    k2c_cnt_valid;
  logic [C_CNT_WIDTH-1:0]  k2c_cnt;
  logic                    k2c_noncontig;

  logic                    c2k_valid;
  logic [C_CNT_WIDTH-1:0]  c2k_cnt;
  logic                    c2k_keep_valid;
  logic [C_KEEP_WIDTH-1:0] c2k_keep;
  logic                    c2k_ovf;

  modport master (
    output k2c_valid, k2c_keep, c2k_valid, c2k_cnt,
    input  k2c_cnt_valid, k2c_cnt, k2c_noncontig,
    input  c2k_keep_valid, c2k_keep, c2k_ovf
  );

  modport slave (
    input  k2c_valid, k2c_keep, c2k_valid, c2k_cnt,
    output k2c_cnt_valid, k2c_cnt, k2c_noncontig,
    output c2k_keep_valid, c2k_keep, c2k_ovf
  );
endinterface

`default_nettype wire

// File: rtl/keep_cnt_conv.sv
// keep_cnt_conv: registered tkeep <-> byte-count converter, two independent 1-cycle channels.
// Rev 1.0
`default_nettype none

module keep_cnt_conv #(
  parameter int C_KEEP_WIDTH = 8,
  parameter int C_CNT_WIDTH  = 4
) (
  input  wire logic          clk,
  input  wire logic          rst,
  keep_cnt_conv_if.slave     bus
);

  localparam logic [C_CNT_WIDTH-1:0] C_MAX_CNT = C_CNT_WIDTH'(C_KEEP_WIDTH);

  logic [C_CNT_WIDTH-1:0]  w_popcnt;
  logic [C_KEEP_WIDTH:0]   w_keep_ext;
  logic [C_KEEP_WIDTH:0]   w_keep_inc;
  logic                    w_noncontig;
  logic                    w_ovf;
  logic [C_KEEP_WIDTH-1:0] w_therm;

  logic                    r_k2c_valid;
  logic [C_CNT_WIDTH-1:0]  r_k2c_cnt;
  logic                    r_k2c_noncontig;
  logic                    r_c2k_valid;
  logic [C_KEEP_WIDTH-1:0] r_c2k_keep;
  logic                    r_c2k_ovf;

  always_comb begin
    w_popcnt = '0;
    for (int i = 0; i < C_KEEP_WIDTH; i++) begin
      w_popcnt = w_popcnt + C_CNT_WIDTH'(bus.k2c_keep[i]);
    end
  end

  // A mask of form 2**n-1 (including 0) has no bit in common with itself plus one.
  assign w_keep_ext  = {1'b0, bus.k2c_keep};
  assign w_keep_inc  = w_keep_ext + (C_KEEP_WIDTH+1)'(1);
  assign w_noncontig = |(w_keep_ext & w_keep_inc);

  assign w_ovf = (bus.c2k_cnt > C_MAX_CNT);

  for (genvar gi = 0; gi < C_KEEP_WIDTH; gi++) begin : g_therm
    assign w_therm[gi] = w_ovf | (C_CNT_WIDTH'(gi) < bus.c2k_cnt);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_k2c_valid     <= 1'b0;
      r_k2c_cnt       <= '0;
      r_k2c_noncontig <= 1'b0;
    end else begin
      r_k2c_valid <= bus.k2c_valid;
      if (bus.k2c_valid) begin
        r_k2c_cnt       <= w_popcnt;
        r_k2c_noncontig <= w_noncontig;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_c2k_valid <= 1'b0;
      r_c2k_keep  <= '0;
      r_c2k_ovf   <= 1'b0;
    end else begin
      r_c2k_valid <= bus.c2k_valid;
      if (bus.c2k_valid) begin
        r_c2k_keep <= w_therm;
        r_c2k_ovf  <= w_ovf;
      end
    end
  end

  assign bus.k2c_cnt_valid  = r_k2c_valid;
  assign bus.k2c_cnt        = r_k2c_cnt;
  assign bus.k2c_noncontig  = r_k2c_noncontig;
  assign bus.c2k_keep_valid = r_c2k_valid;
  assign bus.c2k_keep       = r_c2k_keep;
  assign bus.c2k_ovf        = r_c2k_ovf;

endmodule

`default_nettype wire

// File: tb/tb_keep_cnt_conv.sv
// tb_keep_cnt_conv: directed self-checking bench for keep_cnt_conv (W=8, CNT=4).
// Rev 1.0
`default_nettype none

module tb_keep_cnt_conv;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_fail;

  keep_cnt_conv_if #(.C_KEEP_WIDTH(8), .C_CNT_WIDTH(4)) bus_if ();

  keep_cnt_conv #(.C_KEEP_WIDTH(8), .C_CNT_WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] sweep_keep [0:5] = '{8'h00, 8'h01, 8'h03, 8'h0F, 8'h7F, 8'hFF};
  logic [3:0] sweep_cnt  [0:5] = '{4'd0, 4'd1, 4'd2, 4'd4, 4'd7, 4'd8};
  logic [7:0] nc_keep    [0:2] = '{8'h05, 8'h80, 8'hFE};
  logic [3:0] nc_cnt     [0:2] = '{4'd2, 4'd1, 4'd7};
  logic [3:0] c2k_in     [0:10] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd15};
  logic [7:0] c2k_exp    [0:10] = '{8'h00, 8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F,
                                    8'hFF, 8'hFF, 8'hFF};
  logic       c2k_ovf_e  [0:10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    assert (act === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic expect_k2c(input string tag, input logic v, input logic [3:0] cnt, input logic nc);
    chk({tag, ".k2c_cnt_valid"}, 32'(bus_if.k2c_cnt_valid), 32'(v));
    chk({tag, ".k2c_cnt"},       32'(bus_if.k2c_cnt),       32'(cnt));
    chk({tag, ".k2c_noncontig"}, 32'(bus_if.k2c_noncontig), 32'(nc));
  endtask

  task automatic expect_c2k(input string tag, input logic v, input logic [7:0] keep, input logic ovf);
    chk({tag, ".c2k_keep_valid"}, 32'(bus_if.c2k_keep_valid), 32'(v));
    chk({tag, ".c2k_keep"},       32'(bus_if.c2k_keep),       32'(keep));
    chk({tag, ".c2k_ovf"},        32'(bus_if.c2k_ovf),        32'(ovf));
  endtask

  task automatic drive(input logic kv, input logic [7:0] keep, input logic cv, input logic [3:0] cnt);
    bus_if.k2c_valid = kv;
    bus_if.k2c_keep  = keep;
    bus_if.c2k_valid = cv;
    bus_if.c2k_cnt   = cnt;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;

    // Reset overrides active valids
    rst = 1'b1;
    drive(1'b1, 8'hFF, 1'b1, 4'd8);
    tick(); tick(); tick();
    expect_k2c("rst", 1'b0, 4'd0, 1'b0);
    expect_c2k("rst", 1'b0, 8'h00, 1'b0);

    rst = 1'b0;
    tick();
    expect_k2c("release", 1'b1, 4'd8, 1'b0);
    expect_c2k("release", 1'b1, 8'hFF, 1'b0);

    // Contiguous sweep, back-to-back; c2k idle and holding
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, sweep_keep[i], 1'b0, 4'd0);
      tick();
      expect_k2c($sformatf("k2c_sweep%0d", i), 1'b1, sweep_cnt[i], 1'b0);
      expect_c2k($sformatf("c2k_idle%0d", i), 1'b0, 8'hFF, 1'b0);
    end

    for (int i = 0; i < 3; i++) begin
      drive(1'b1, nc_keep[i], 1'b0, 4'd0);
      tick();
      expect_k2c($sformatf("noncontig%0d", i), 1'b1, nc_cnt[i], 1'b1);
    end

    // Count-to-keep sweep including saturation; k2c holds cnt 7 / noncontig 1
    for (int i = 0; i < 11; i++) begin
      drive(1'b0, 8'h00, 1'b1, c2k_in[i]);
      tick();
      expect_c2k($sformatf("c2k_sweep%0d", i), 1'b1, c2k_exp[i], c2k_ovf_e[i]);
      expect_k2c($sformatf("k2c_hold%0d", i), 1'b0, 4'd7, 1'b1);
    end

    // Gap: valid 1,0,1
    drive(1'b1, 8'h0F, 1'b0, 4'd0);
    tick();
    expect_k2c("gap_a", 1'b1, 4'd4, 1'b0);
    drive(1'b0, 8'h03, 1'b0, 4'd0);
    tick();
    expect_k2c("gap_b", 1'b0, 4'd4, 1'b0);
    drive(1'b1, 8'h03, 1'b0, 4'd0);
    tick();
    expect_k2c("gap_c", 1'b1, 4'd2, 1'b0);

    drive(1'b0, 8'h00, 1'b1, 4'd3);
    tick();
    expect_c2k("c2k_gap_a", 1'b1, 8'h07, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 4'd9);
    tick();
    expect_c2k("c2k_gap_b", 1'b0, 8'h07, 1'b0);

    // Concurrent round trip
    for (int c = 0; c < 9; c++) begin
      drive(1'b1, c2k_exp[c], 1'b1, 4'(c));
      tick();
      expect_k2c($sformatf("rt%0d", c), 1'b1, 4'(c), 1'b0);
      expect_c2k($sformatf("rt%0d", c), 1'b1, c2k_exp[c], 1'b0);
    end

    // Mid-stream reset drops in-flight data
    drive(1'b1, 8'hFF, 1'b1, 4'd9);
    tick();
    expect_k2c("mid_pre", 1'b1, 4'd8, 1'b0);
    expect_c2k("mid_pre", 1'b1, 8'hFF, 1'b1);
    rst = 1'b1;
    drive(1'b1, 8'h05, 1'b1, 4'd12);
    tick();
    expect_k2c("mid_rst", 1'b0, 4'd0, 1'b0);
    expect_c2k("mid_rst", 1'b0, 8'h00, 1'b0);
    rst = 1'b0;
    drive(1'b1, 8'h01, 1'b1, 4'd2);
    tick();
    expect_k2c("mid_post", 1'b1, 4'd1, 1'b0);
    expect_c2k("mid_post", 1'b1, 8'h03, 1'b0);
    drive(1'b0, 8'hAA, 1'b0, 4'd15);
    tick();
    expect_k2c("mid_idle", 1'b0, 4'd1, 1'b0);
    expect_c2k("mid_idle", 1'b0, 8'h03, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
